isp_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator for the ISP chain. It consumes the raster-order vsync/valid/data pixel stream and emits, per input pixel, the 3x3 window whose bottom-right element is that pixel, packed into one wide bus. It sits directly upstream of the spatial filters (sharpen, blur, Sobel). Those filters use the N-stage video delay stage to re-align vsync/valid with their own arithmetic latency. Line storage is two on-chip line buffers of IMG_WIDTH entries each.

---
 rtl/isp_window_3x3.sv | 135 +++++++++++++
 tb/tb_isp_window_3x3.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/isp_window_3x3.sv
// isp_window_3x3: streaming 3x3 neighbourhood generator.
// Two line buffers plus per-row column shifters; 2-cycle latency.
module isp_window_3x3 #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720,
  parameter int DATA_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vsync_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    vsync_o,
  output logic                    valid_o,
  output logic [9*DATA_WIDTH-1:0] win_o
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int DW = DATA_WIDTH;

  logic          vs1_q, vs2_q;
  logic          v1_q, v2_q;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic          fs;

  logic [XW-1:0] x1_q;
  logic [YW-1:0] y1_q;
  logic [DW-1:0] d1_q, rd0_q, rd1_q;

  logic [DW-1:0] lb0_q [IMG_WIDTH];
  logic [DW-1:0] lb1_q [IMG_WIDTH];

  logic [2:0][1:0][DW-1:0] sr_q;
  logic [2:0][2:0][DW-1:0] taps;
  logic [9*DW-1:0]         win_q, win_d;

  logic xlt1, xlt2, ylt1, ylt2;

  // Frame start overrides the running position for this cycle's pixel.
  always_comb begin
    fs    = vsync_i & ~vs1_q;
    cur_x = fs ? '0 : x_q;
    cur_y = fs ? '0 : y_q;
    x_d   = cur_x;
    y_d   = cur_y;
    if (valid_i) begin
      if (cur_x == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        if (cur_y != YW'(IMG_HEIGHT - 1)) begin
          y_d = cur_y + 1'b1;
        end
      end else begin
        x_d = cur_x + 1'b1;
      end
    end
  end

  // Position counters, vsync history and the valid/vsync delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      vs1_q <= 1'b0;
      vs2_q <= 1'b0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      vs1_q <= vsync_i;
      vs2_q <= vs1_q;
      v1_q  <= valid_i;
      v2_q  <= v1_q;
    end
  end

  // Line buffer cascade: read both rows, then push the new pixel down.
  always_ff @(posedge clk) begin
    if (valid_i) begin
      rd1_q        <= lb1_q[cur_x];
      rd0_q        <= lb0_q[cur_x];
      lb1_q[cur_x] <= data_i;
      lb0_q[cur_x] <= lb1_q[cur_x];
      d1_q         <= data_i;
      x1_q         <= cur_x;
      y1_q         <= cur_y;
    end
  end

  // Assemble the window from shifters plus the new column, edge-masked.
  always_comb begin
    xlt1 = (x1_q == '0);
    xlt2 = (x1_q <= XW'(1));
    ylt1 = (y1_q == '0);
    ylt2 = (y1_q <= YW'(1));
    taps[0] = {rd0_q, sr_q[0][1], sr_q[0][0]};
    taps[1] = {rd1_q, sr_q[1][1], sr_q[1][0]};
    taps[2] = {d1_q,  sr_q[2][1], sr_q[2][0]};
    win_d   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((c == 0 && xlt2) || (c == 1 && xlt1) ||
              (r == 0 && ylt2) || (r == 1 && ylt1))) begin
          win_d[DW*(3*r+c) +: DW] = taps[r][c];
        end
      end
    end
  end

  // Column shifters advance only on valid pixels.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      for (int r = 0; r < 3; r++) begin
        sr_q[r][0] <= sr_q[r][1];
        sr_q[r][1] <= taps[r][2];
      end
    end
  end

  // Output window register; holds when no pixel is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
    end else if (v1_q) begin
      win_q <= win_d;
    end
  end

  assign vsync_o = vs2_q;
  assign valid_o = v2_q;
  assign win_o   = win_q;

endmodule

// File: tb/tb_isp_window_3x3.sv
// tb_isp_window_3x3: scoreboard bench for the 3x3 window generator.
// Small 8x4 image, pixel = 0x10*(y+1) + (x+1).
module tb_isp_window_3x3;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int BW = 9 * DW;

  logic          clk;
  logic          rst;
  logic          vsync_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          vsync_o;
  logic          valid_o;
  logic [BW-1:0] win_o;

  int nchk;
  int nerr;
  int vcnt;

  logic [BW-1:0] sb[$];
  logic [1:0]    vs_h, v_h;

  isp_window_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_WIDTH(DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .vsync_i(vsync_i),
    .valid_i(valid_i),
    .data_i (data_i),
    .vsync_o(vsync_o),
    .valid_o(valid_o),
    .win_o  (win_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [BW-1:0] got, logic [BW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(int x, int y);
    return DW'(16 * (y + 1) + x + 1);
  endfunction

  function automatic logic [BW-1:0] exp_win(int x, int y);
    logic [BW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (y - 2 + r >= 0 && x - 2 + c >= 0) begin
          w[DW*(3*r+c) +: DW] = pix(x - 2 + c, y - 2 + r);
        end
      end
    end
    return w;
  endfunction

  // Reference 2-cycle delay of vsync/valid, cleared by reset.
  always @(posedge clk) begin
    if (rst) begin
      vs_h <= '0;
      v_h  <= '0;
    end else begin
      vs_h <= {vs_h[0], vsync_i};
      v_h  <= {v_h[0], valid_i};
    end
  end

  always @(negedge clk) begin
    chk("vsync_o", BW'(vsync_o), BW'(vs_h[1]));
    chk("valid_o", BW'(valid_o), BW'(v_h[1]));
    if (valid_o === 1'b1) begin
      vcnt++;
      if (sb.size() == 0) begin
        chk("sb_empty", BW'(1), BW'(0));
      end else begin
        chk("win", win_o, sb.pop_front());
      end
    end
  end

  task automatic drive(bit vs, bit vld, int x, int y);
    @(posedge clk);
    #1;
    vsync_i = vs;
    valid_i = vld;
    data_i  = vld ? pix(x, y) : DW'($urandom);
    if (vld) sb.push_back(exp_win(x, y));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic frame(bit gaps, bit start_vs);
    if (start_vs) drive(1, 0, 0, 0);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        while (gaps && $urandom_range(1) == 1) drive(0, 0, 0, 0);
        drive(0, 1, x, y);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    vsync_i = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk("rst_vsync", BW'(vsync_o), '0);
    chk("rst_valid", BW'(valid_o), '0);
    chk("rst_win", win_o, '0);
  endtask

  initial begin
    nchk    = 0;
    nerr    = 0;
    vcnt    = 0;
    rst     = 1'b1;
    vsync_i = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    @(posedge clk);
    do_reset();

    frame(0, 1);
    idle(4);

    vcnt = 0;
    frame(1, 1);
    idle(4);
    chk("gap_count", BW'(vcnt), BW'(32));

    drive(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) drive(0, 1, i % W, i / W);
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 0);
    drive(1, 1, 2, 0);
    for (int i = 3; i < W * H; i++) drive(0, 1, i % W, i / W);
    idle(4);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, i, 0);
    do_reset();
    frame(0, 0);
    idle(4);

    chk("sb_left", BW'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
